// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg
//   Shared definitions for the round-robin registered mux/arbiter:
//   default channel width and count, a clog2 constant function used to
//   size the channel index, and a slice macro for the packed request bus.
//   Optional feature macro: RR_MUX_ARB_LOCK_EN (see rr_mux_arb.sv).

`ifndef RR_MUX_ARB_PKG_SV
`define RR_MUX_ARB_PKG_SV

// Channel i of a packed bus of W-bit words occupies bits [i*W +: W].
`define RR_MUX_ARB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package rr_mux_arb_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_CH = 4;

    // Ceiling log2, used to size channel indices (NUM_CH >= 2 gives >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/rr_mux_arb_if.sv
// rr_mux_arb_if
//   Bundles the request side (per-channel valid/data/ready) and the output
//   side (valid/data/sel/ready) of rr_mux_arb.
//   Modports:
//     slave  - the arbiter: consumes requests, produces the output word
//     master - the environment: drives requests and OUT_READY
//   With RR_MUX_ARB_LOCK_EN defined the bundle also carries REQ_LOCK.

interface rr_mux_arb_if
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH
);
    localparam int SEL_W = clog2(NUM_CH);

    logic [NUM_CH-1:0]       REQ_VALID;
    logic [NUM_CH*WIDTH-1:0] REQ_DATA;
    logic [NUM_CH-1:0]       REQ_READY;
`ifdef RR_MUX_ARB_LOCK_EN
    logic [NUM_CH-1:0]       REQ_LOCK;
`endif
    logic                    OUT_VALID;
    logic [WIDTH-1:0]        OUT_DATA;
    logic [SEL_W-1:0]        OUT_SEL;
    logic                    OUT_READY;

    modport slave (
        input  REQ_VALID, REQ_DATA,
`ifdef RR_MUX_ARB_LOCK_EN
        input  REQ_LOCK,
`endif
        output REQ_READY,
        output OUT_VALID, OUT_DATA, OUT_SEL,
        input  OUT_READY
    );

    modport master (
        output REQ_VALID, REQ_DATA,
`ifdef RR_MUX_ARB_LOCK_EN
        output REQ_LOCK,
`endif
        input  REQ_READY,
        input  OUT_VALID, OUT_DATA, OUT_SEL,
        output OUT_READY
    );

endinterface

// File: rtl/rr_mux_arb_grant_ptr.sv
// rr_grant_ptr
//   Round-robin grant generator. Searches req_valid starting at the
//   registered priority pointer, wrapping modulo NUM_CH, and reports the
//   first valid channel as a one-hot grant plus its index. On an accept
//   the pointer moves one past the granted channel.
//   With RR_MUX_ARB_LOCK_EN defined, a granted channel whose req_lock bit
//   is set keeps the pointer, so it stays top priority next cycle.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset (pointer -> 0)
//     req_valid  - per-channel request valid
//     req_lock   - per-channel lock request (lock build only)
//     accept     - the granted request is taken this cycle
//     grant_oh   - one-hot grant (zero when nothing is valid)
//     grant_idx  - index of the granted channel
//     grant_any  - at least one channel is valid

module rr_grant_ptr
    import rr_mux_arb_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_valid,
`ifdef RR_MUX_ARB_LOCK_EN
    input  logic [NUM_CH-1:0] req_lock,
`endif
    input  logic              accept,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_any
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] ptr_next;

    // Priority search from ptr_q; the first hit wins.
    always_comb begin
        int c;
        c         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!grant_any && req_valid[c]) begin
                grant_any = 1'b1;
                grant_idx = SEL_W'(c);
            end
        end
        grant_oh = grant_any ? (NUM_CH'(1) << grant_idx) : '0;
    end

    // NUM_CH need not be a power of two, so wrap explicitly.
    assign ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
`ifdef RR_MUX_ARB_LOCK_EN
            ptr_d = req_lock[grant_idx] ? grant_idx : ptr_next;
`else
            ptr_d = ptr_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb
//   NUM_CH-channel, WIDTH-bit registered mux with a round-robin arbiter.
//   One request is accepted per cycle whenever the output register is empty
//   or being drained; the accepted word, and the index of the channel that
//   supplied it, appear on the output one cycle later.
//   Ports:
//     CLK  - rising-edge clock
//     RST  - synchronous, active-high reset (empties the output register)
//     bus  - rr_mux_arb_if.slave: REQ_VALID/REQ_DATA/REQ_READY per channel,
//            OUT_VALID/OUT_DATA/OUT_SEL/OUT_READY on the output
//   Optional feature macro: RR_MUX_ARB_LOCK_EN - adds REQ_LOCK so a channel
//   can hold top priority across back-to-back accepts.

module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic        CLK,
    input  logic        RST,
    rr_mux_arb_if.slave bus
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;

    logic              load_ok;
    logic              accept;
    logic [NUM_CH-1:0] grant_oh;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic [WIDTH-1:0]  grant_data;

    // The register may refill in the same cycle it drains.
    assign load_ok = !out_valid_q || bus.OUT_READY;
    assign accept  = grant_any && load_ok && !RST;

    rr_grant_ptr #(
        .NUM_CH (NUM_CH)
    ) u_grant (
        .clk       (CLK),
        .rst       (RST),
        .req_valid (bus.REQ_VALID),
`ifdef RR_MUX_ARB_LOCK_EN
        .req_lock  (bus.REQ_LOCK),
`endif
        .accept    (accept),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.REQ_READY = accept ? grant_oh : '0;
    assign grant_data    = `RR_MUX_ARB_SLICE(bus.REQ_DATA, int'(grant_idx), WIDTH);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
        end else if (out_valid_q && bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb
//   Self-checking bench for rr_mux_arb (WIDTH=32, NUM_CH=4). A reference
//   model tracks the priority pointer and output register in plain integer
//   arithmetic; each scenario task drives stimulus and compares inline.

module tb_rr_mux_arb;

    localparam int W = 32;
    localparam int N = 4;
`ifdef RR_MUX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    rr_mux_arb_if #(.WIDTH(W), .NUM_CH(N)) bus ();

    rr_mux_arb #(.WIDTH(W), .NUM_CH(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    logic [3:0]  obs_ready;
    logic [3:0]  exp_ready;
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    logic [127:0] rr_data;

    // One clock cycle: drive inputs at the falling edge, sample REQ_READY
    // before the rising edge, update the model at the rising edge.
    task automatic cycle(input bit r, input logic [3:0] v, input logic [127:0] d,
                         input bit ordy, input logic [3:0] lk);
        int g;
        bit load_ok;
        @(negedge clk);
        rst           = r;
        bus.REQ_VALID = v;
        bus.REQ_DATA  = d;
        bus.OUT_READY = ordy;
`ifdef RR_MUX_ARB_LOCK_EN
        bus.REQ_LOCK  = lk;
`endif
        #1;
        obs_ready = bus.REQ_READY;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        load_ok   = !m_valid || ordy;
        exp_ready = (!r && load_ok && g >= 0) ? 4'(1 << g) : 4'b0000;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (g >= 0 && load_ok) begin
            m_valid = 1'b1;
            m_data  = d[g*W +: W];
            m_sel   = g;
            m_ptr   = (LOCK_EN && lk[g]) ? g : (g + 1) % N;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4'b1111, rr_data, 1'b1, 4'b0000);
            n_checks++;
            if (obs_ready !== 4'b0000) begin
                n_fail++; $display("FAIL reset_ready got=%b exp=0000", obs_ready);
            end
            n_checks++;
            if (bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== 32'h0 || bus.OUT_SEL !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0",
                         bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL);
            end
        end
        cycle(1'b0, 4'b1111, rr_data, 1'b1, 4'b0000);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", obs_ready);
        end
        n_checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_SEL !== 2'd0) begin
            n_fail++; $display("FAIL reset_first_sel got v=%b s=%0d exp v=1 s=0",
                               bus.OUT_VALID, bus.OUT_SEL);
        end
    endtask

    task automatic test_round_robin();
        cycle(1'b1, 4'b0000, rr_data, 1'b1, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'b1111, rr_data, 1'b1, 4'b0000);
            n_checks++;
            if (obs_ready !== 4'(1 << (k % N))) begin
                n_fail++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, obs_ready, 4'(1 << (k % N)));
            end
            n_checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_SEL !== 2'(k % N) ||
                bus.OUT_DATA !== 32'(k % N) * 32'h1111_1111) begin
                n_fail++;
                $display("FAIL rr_out k=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", k,
                         bus.OUT_VALID, bus.OUT_SEL, bus.OUT_DATA, k % N, 32'(k % N) * 32'h1111_1111);
            end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 4'b0000, rr_data, 1'b1, 4'b0000);
        cycle(1'b0, 4'b0100, rr_data, 1'b1, 4'b0000);  // pointer moves to 3
        cycle(1'b0, 4'b0100, rr_data, 1'b1, 4'b0000);
        n_checks++;
        if (obs_ready !== 4'b0100 || bus.OUT_SEL !== 2'd2 || bus.OUT_DATA !== 32'h2222_2222) begin
            n_fail++; $display("FAIL wrap_grant2 got r=%b s=%0d d=%h exp r=0100 s=2 d=22222222",
                               obs_ready, bus.OUT_SEL, bus.OUT_DATA);
        end
        cycle(1'b0, 4'b1001, rr_data, 1'b1, 4'b0000);
        n_checks++;
        if (obs_ready !== 4'b1000 || bus.OUT_SEL !== 2'd3) begin
            n_fail++; $display("FAIL wrap_ptr3 got r=%b s=%0d exp r=1000 s=3", obs_ready, bus.OUT_SEL);
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 4'b0000, rr_data, 1'b1, 4'b0000);
        cycle(1'b0, 4'b1111, rr_data, 1'b0, 4'b0000);  // loads channel 0
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, rr_data, 1'b0, 4'b0000);
            n_checks++;
            if (obs_ready !== 4'b0000 || bus.OUT_VALID !== 1'b1 ||
                bus.OUT_SEL !== 2'd0 || bus.OUT_DATA !== 32'h0) begin
                n_fail++; $display("FAIL stall_hold i=%0d got r=%b v=%b s=%0d d=%h exp r=0000 v=1 s=0 d=0",
                                   i, obs_ready, bus.OUT_VALID, bus.OUT_SEL, bus.OUT_DATA);
            end
        end
        cycle(1'b0, 4'b1111, rr_data, 1'b1, 4'b0000);
        n_checks++;
        if (obs_ready !== 4'b0010 || bus.OUT_VALID !== 1'b1 ||
            bus.OUT_SEL !== 2'd1 || bus.OUT_DATA !== 32'h1111_1111) begin
            n_fail++; $display("FAIL stall_refill got r=%b v=%b s=%0d d=%h exp r=0010 v=1 s=1 d=11111111",
                               obs_ready, bus.OUT_VALID, bus.OUT_SEL, bus.OUT_DATA);
        end
    endtask

    task automatic test_reset_midflight();
        cycle(1'b1, 4'b0000, rr_data, 1'b1, 4'b0000);
        cycle(1'b0, 4'b0100, rr_data, 1'b0, 4'b0000);  // holds channel 2 word
        cycle(1'b1, 4'b0100, rr_data, 1'b0, 4'b0000);
        n_checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== 32'h0 || obs_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_clear got v=%b d=%h r=%b exp v=0 d=0 r=0000",
                               bus.OUT_VALID, bus.OUT_DATA, obs_ready);
        end
        cycle(1'b0, 4'b1111, rr_data, 1'b1, 4'b0000);
        n_checks++;
        if (bus.OUT_SEL !== 2'd0 || bus.OUT_DATA !== 32'h0 || obs_ready !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_ptr0 got s=%0d d=%h r=%b exp s=0 d=0 r=0001",
                               bus.OUT_SEL, bus.OUT_DATA, obs_ready);
        end
    endtask

    task automatic test_random();
        logic [3:0]   v;
        logic [3:0]   lk;
        logic [127:0] d;
        bit           r;
        bit           ordy;
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            v    = 4'($urandom_range(0, 15));
            lk   = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0);
            d    = {$urandom, $urandom, $urandom, $urandom};
            cycle(r, v, d, ordy, lk);
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, obs_ready, exp_ready);
            end
            n_checks++;
            if (bus.OUT_VALID !== m_valid || bus.OUT_DATA !== m_data || bus.OUT_SEL !== 2'(m_sel)) begin
                n_fail++; $display("FAIL rand_out i=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", i,
                                   bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL, m_valid, m_data, m_sel);
            end
        end
    endtask

`ifdef RR_MUX_ARB_LOCK_EN
    task automatic test_lock();
        int exp_sel [6] = '{1, 1, 1, 1, 3, 0};
        logic [3:0] lk;
        cycle(1'b1, 4'b0000, rr_data, 1'b1, 4'b0000);
        cycle(1'b0, 4'b0001, rr_data, 1'b1, 4'b0000);  // pointer moves to 1
        for (int i = 0; i < 6; i++) begin
            lk = (i < 3) ? 4'b0010 : 4'b0000;
            cycle(1'b0, 4'b1011, rr_data, 1'b1, lk);
            n_checks++;
            if (bus.OUT_SEL !== 2'(exp_sel[i]) || bus.OUT_VALID !== 1'b1) begin
                n_fail++; $display("FAIL lock_seq i=%0d got s=%0d v=%b exp s=%0d v=1",
                                   i, bus.OUT_SEL, bus.OUT_VALID, exp_sel[i]);
            end
        end
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_DATA  = '0;
        bus.OUT_READY = 1'b0;
`ifdef RR_MUX_ARB_LOCK_EN
        bus.REQ_LOCK  = '0;
`endif
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        for (int i = 0; i < N; i++) begin
            rr_data[i*W +: W] = 32'(i) * 32'h1111_1111;
        end

        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_reset_midflight();
`ifdef RR_MUX_ARB_LOCK_EN
        test_lock();
`endif
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel, W-bit registered mux with a round-robin arbiter and valid/ready handshakes on every input and on the output.
- Successor to the fixed-size combinational 32-bit muxes: the select is generated internally by fair arbitration rather than driven externally, and the selected word is registered.
- Merges several producers (e.g. register-file read clients, memory request sources) onto one shared datapath.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- NUM_CH, 4, number of input channels (2..32).
- SEL_W, derived ceil(log2(NUM_CH)), width of the channel index; not overridable.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- REQ_VALID  input  NUM_CH  per-channel request valid
- REQ_DATA  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- REQ_READY  output  NUM_CH  one-hot accept strobe; combinational
- OUT_VALID  output  1  output register holds a word
- OUT_DATA  output  WIDTH  registered selected word
- OUT_SEL  output  SEL_W  index of the channel that supplied OUT_DATA
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle

Behaviour:
- Reset (RST=1 at a CLK edge):
  - OUT_VALID=0, OUT_DATA=0, OUT_SEL=0.
  - Priority pointer PTR=0, so channel 0 has highest priority after reset.
  - REQ_READY=0 while RST is high.
  - A word held at reset is discarded.
- Load enable: LOAD_OK = !OUT_VALID | OUT_READY, so the register may refill in the same cycle it drains.
- Arbitration (combinational):
  - Search channels PTR, PTR+1, ..., wrapping modulo NUM_CH.
  - The first channel with REQ_VALID=1 is granted: G.
  - REQ_READY[G] = LOAD_OK & !RST; all other REQ_READY bits are 0.
  - No REQ_READY bit may depend on OUT_DATA.
- On a clock edge with an accept (REQ_VALID[G] & REQ_READY[G]):
  - OUT_DATA <= REQ_DATA[G]; OUT_SEL <= G; OUT_VALID <= 1.
  - PTR <= (G+1) mod NUM_CH, wrapping at NUM_CH-1 -> 0.
- Drain without accept: OUT_VALID & OUT_READY with no request valid -> OUT_VALID <= 0. OUT_DATA and OUT_SEL hold their last values.
- Stall: OUT_VALID=1 & OUT_READY=0 -> all REQ_READY=0. OUT_DATA, OUT_SEL and PTR are held stable.
- Idle: no REQ_VALID -> PTR unchanged, no state change except a drain.
- Latency: accept to OUT_VALID is 1 cycle.
- Throughput: 1 word/cycle when OUT_READY is held high.
- Fairness: with all channels continuously valid, grants cycle 0,1,...,NUM_CH-1,0...; no channel waits more than NUM_CH-1 grants.
- Producers must hold REQ_DATA stable while REQ_VALID=1 and not accepted. The block does not check this.

Optional Feature:
- Macro: RR_MUX_ARB_LOCK_EN.
- When defined:
  - Adds input port REQ_LOCK, width NUM_CH.
  - If the accepted channel G has REQ_LOCK[G]=1, PTR <= G instead of G+1, so G keeps top priority for back-to-back transfers.
  - The lock releases on the first accept with REQ_LOCK[G]=0, or when G is not valid during a grant opportunity. Normal rotation then resumes.
  - RST clears any lock.
- When undefined: the port is absent and the block is pure round-robin as above.

Decomposition:
- Shared definitions file:
  - default WIDTH (32) and NUM_CH (4);
  - a clog2 constant function used to derive SEL_W;
  - the channel-slice macro for REQ_DATA.
- Sub-module rr_grant_ptr:
  - combinational rotate / priority-search / one-hot grant plus the registered PTR, including lock handling;
  - parametrised by NUM_CH.
- The top level holds the output register, the handshake logic, and a data mux indexed by the grant.

Test Plan:
- Reset with REQ_VALID=4'b1111 and RST=1 for 2 cycles -> REQ_READY=0, OUT_VALID=0, OUT_DATA=0. First grant after release goes to channel 0.
- All 4 channels valid, OUT_READY=1, REQ_DATA=i*0x1111_1111 -> OUT_SEL sequence 0,1,2,3,0 on consecutive cycles, OUT_DATA matching, one word per cycle.
- Only channel 2 valid, PTR=3 -> wrap search grants 2. OUT_SEL=2 one cycle later; next PTR=3.
- OUT_READY=0 for 5 cycles with OUT_VALID=1 -> REQ_READY=0 throughout and OUT_DATA held. OUT_READY=1 -> drain and refill in the same cycle.
- RST asserted while OUT_VALID=1 and OUT_READY=0 -> next cycle OUT_VALID=0, PTR=0, and the held word is never delivered.
- With RR_MUX_ARB_LOCK_EN, channel 1 locked for 3 accepts while channels 0 and 3 are valid -> OUT_SEL=1,1,1. The unlocked accept is followed by OUT_SEL=3, then 0.
